// File: rtl/axi_mem_pkg.sv
// Shared AXI response/burst codes and FSM state types for the AXI memory slave.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_mem_if.sv
// AXI4 bundle between the bridge's user port and the memory slave.
// Every channel transfers on a rising clk edge where valid and ready are both high;
// valid never waits on ready, and payload is held stable while valid is high and ready low.
interface axi_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) ();
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic                wvalid, wready, wlast;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;

    logic            bvalid, bready;
    logic [1:0]      bresp;
    logic [ID_W-1:0] bid;

    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid, rready, rlast;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic [ID_W-1:0]   rid;

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );
endinterface

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port with enable.
module axi_mem_ram #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   wstrb_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);
    logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;

    // Non-blocking read and write in one block give read-first on a same-word collision.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
        for (int b = 0; b < DATA_W / 8; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave: independent write (AW/W/B) and read (AR/R) FSMs over one shared RAM.
module axi_slave_mem
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int ID_W       = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    axi_mem_if.slave    s_axi_if,
    output logic [15:0] wr_done_cnt,
    output logic [15:0] rd_done_cnt,
    output wr_state_t   wr_state_o,
    output rd_state_t   rd_state_o
);
    localparam int BYTES    = DATA_W / 8;
    localparam int BYTE_LSB = $clog2(BYTES);
    localparam int IDX_HI   = DEPTH_LOG2 + BYTE_LSB - 1;
    localparam logic [63:0]       MEM_BYTES = 64'(BYTES) << DEPTH_LOG2;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES);

    // Decode errors take priority over slave errors; both cover the whole burst.
    function automatic logic [1:0] burst_resp(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] end_byte;
        end_byte = 64'(addr) + (64'(len) + 64'd1) * 64'(BYTES);
        if (64'(addr) >= MEM_BYTES || (burst == BURST_INCR && end_byte > MEM_BYTES))
            return RESP_DECERR;
        if (size != 3'(BYTE_LSB) || burst == BURST_WRAP || burst == BURST_RSVD)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    logic run_q;
    wr_state_t wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ID_W-1:0] wid_q, wid_d;
    logic [7:0] wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [1:0] wburst_q, wburst_d, werr_q, werr_d, bresp_q, bresp_d;
    logic wlate_q, wlate_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic awready, wready, bvalid, w_last_beat, w_mismatch, ram_we;

    rd_state_t rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, raddr_nxt;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [7:0] rlen_q, rlen_d, rbeat_q, rbeat_d;
    logic [1:0] rburst_q, rburst_d, rerr_q, rerr_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic arready, rvalid, r_last_beat, ram_re;
    logic [DEPTH_LOG2-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    // Holds both ready outputs low until the first clock edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) run_q <= 1'b0;
        else     run_q <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            waddr_q    <= '0;
            wid_q      <= '0;
            wlen_q     <= '0;
            wbeat_q    <= '0;
            wburst_q   <= '0;
            werr_q     <= '0;
            bresp_q    <= '0;
            wlate_q    <= 1'b0;
            wr_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            waddr_q    <= waddr_d;
            wid_q      <= wid_d;
            wlen_q     <= wlen_d;
            wbeat_q    <= wbeat_d;
            wburst_q   <= wburst_d;
            werr_q     <= werr_d;
            bresp_q    <= bresp_d;
            wlate_q    <= wlate_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    always_comb begin
        wr_state_d  = wr_state_q;
        waddr_d     = waddr_q;
        wid_d       = wid_q;
        wlen_d      = wlen_q;
        wbeat_d     = wbeat_q;
        wburst_d    = wburst_q;
        werr_d      = werr_q;
        bresp_d     = bresp_q;
        wlate_d     = wlate_q;
        wr_cnt_d    = wr_cnt_q;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        ram_we      = 1'b0;
        w_last_beat = (wbeat_q == wlen_q);
        w_mismatch  = (s_axi_if.wlast != w_last_beat);
        case (wr_state_q)
            W_IDLE: begin
                awready = run_q;
                if (run_q && s_axi_if.awvalid) begin
                    waddr_d    = s_axi_if.awaddr;
                    wid_d      = s_axi_if.awid;
                    wlen_d     = s_axi_if.awlen;
                    wburst_d   = s_axi_if.awburst;
                    werr_d     = burst_resp(s_axi_if.awaddr, s_axi_if.awlen,
                                            s_axi_if.awsize, s_axi_if.awburst);
                    wbeat_d    = '0;
                    wlate_d    = 1'b0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                wready = 1'b1;
                if (s_axi_if.wvalid) begin
                    // Once wlast has misbehaved the remaining beats are dropped.
                    ram_we  = (werr_q == RESP_OKAY) && !wlate_q;
                    wlate_d = wlate_q || w_mismatch;
                    waddr_d = (wburst_q == BURST_INCR) ? waddr_q + ADDR_STEP : waddr_q;
                    wbeat_d = wbeat_q + 8'd1;
                    if (w_last_beat) begin
                        bresp_d    = (werr_q != RESP_OKAY) ? werr_q :
                                     (wlate_d ? RESP_SLVERR : RESP_OKAY);
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (s_axi_if.bready) begin
                    wr_cnt_d   = wr_cnt_q + 16'd1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            raddr_q    <= '0;
            rid_q      <= '0;
            rlen_q     <= '0;
            rbeat_q    <= '0;
            rburst_q   <= '0;
            rerr_q     <= '0;
            rd_cnt_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            raddr_q    <= raddr_d;
            rid_q      <= rid_d;
            rlen_q     <= rlen_d;
            rbeat_q    <= rbeat_d;
            rburst_q   <= rburst_d;
            rerr_q     <= rerr_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    always_comb begin
        rd_state_d  = rd_state_q;
        raddr_d     = raddr_q;
        rid_d       = rid_q;
        rlen_d      = rlen_q;
        rbeat_d     = rbeat_q;
        rburst_d    = rburst_q;
        rerr_d      = rerr_q;
        rd_cnt_d    = rd_cnt_q;
        arready     = 1'b0;
        rvalid      = 1'b0;
        ram_re      = 1'b0;
        raddr_nxt   = (rburst_q == BURST_FIXED) ? raddr_q : raddr_q + ADDR_STEP;
        ram_raddr   = raddr_nxt[IDX_HI:BYTE_LSB];
        r_last_beat = (rbeat_q == rlen_q);
        case (rd_state_q)
            R_IDLE: begin
                arready = run_q;
                if (run_q && s_axi_if.arvalid) begin
                    raddr_d    = s_axi_if.araddr;
                    rid_d      = s_axi_if.arid;
                    rlen_d     = s_axi_if.arlen;
                    rburst_d   = s_axi_if.arburst;
                    rerr_d     = burst_resp(s_axi_if.araddr, s_axi_if.arlen,
                                            s_axi_if.arsize, s_axi_if.arburst);
                    rbeat_d    = '0;
                    ram_re     = 1'b1;
                    ram_raddr  = s_axi_if.araddr[IDX_HI:BYTE_LSB];
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rvalid = 1'b1;
                // The next beat is fetched only on a handshake, so a stall leaves rdata untouched.
                if (s_axi_if.rready) begin
                    if (r_last_beat) begin
                        rd_cnt_d   = rd_cnt_q + 16'd1;
                        rd_state_d = R_IDLE;
                    end else begin
                        rbeat_d = rbeat_q + 8'd1;
                        raddr_d = raddr_nxt;
                        ram_re  = 1'b1;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    axi_mem_ram #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (waddr_q[IDX_HI:BYTE_LSB]),
        .wdata_i (s_axi_if.wdata),
        .wstrb_i (s_axi_if.wstrb),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign s_axi_if.awready = awready;
    assign s_axi_if.wready  = wready;
    assign s_axi_if.bvalid  = bvalid;
    assign s_axi_if.bresp   = bvalid ? bresp_q : RESP_OKAY;
    assign s_axi_if.bid     = bvalid ? wid_q : '0;
    assign s_axi_if.arready = arready;
    assign s_axi_if.rvalid  = rvalid;
    assign s_axi_if.rdata   = (rvalid && rerr_q == RESP_OKAY) ? ram_rdata : '0;
    assign s_axi_if.rresp   = rvalid ? rerr_q : RESP_OKAY;
    assign s_axi_if.rid     = rvalid ? rid_q : '0;
    assign s_axi_if.rlast   = rvalid && r_last_beat;

    assign wr_done_cnt = wr_cnt_q;
    assign rd_done_cnt = rd_cnt_q;
    assign wr_state_o  = wr_state_q;
    assign rd_state_o  = rd_state_q;
endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: drivers push expected B/R responses, a negedge monitor checks them.
module tb_axi_slave_mem;
    import axi_mem_pkg::*;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wr_done_cnt, rd_done_cnt;
    wr_state_t   wr_state;
    rd_state_t   rd_state;

    int     checks = 0;
    int     failures = 0;
    int     exp_wr_cnt = 0;
    int     exp_rd_cnt = 0;
    b_exp_t exp_b_q[$];
    r_exp_t exp_r_q[$];
    logic   rready_toggle = 1'b0;
    logic   stall_seen = 1'b0;
    logic [31:0] stall_data = '0;

    axi_mem_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    axi_slave_mem #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .DEPTH_LOG2(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axi_if    (bus),
        .wr_done_cnt (wr_done_cnt),
        .rd_done_cnt (rd_done_cnt),
        .wr_state_o  (wr_state),
        .rd_state_o  (rd_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one sample per cycle, half a period away from the active edge.
    always @(negedge clk) begin
        b_exp_t be;
        r_exp_t re;
        if (!rst && bus.bvalid && bus.bready) begin
            if (exp_b_q.size() == 0) begin
                check("b_unexpected_bvalid", bus.bvalid, 0);
            end else begin
                be = exp_b_q.pop_front();
                check("bresp", bus.bresp, be.resp);
                check("bid", bus.bid, be.id);
            end
        end
        if (!rst && bus.rvalid && bus.rready) begin
            if (exp_r_q.size() == 0) begin
                check("r_unexpected_rvalid", bus.rvalid, 0);
            end else begin
                re = exp_r_q.pop_front();
                check("rdata", bus.rdata, re.data);
                check("rresp", bus.rresp, re.resp);
                check("rlast", bus.rlast, re.last);
                check("rid", bus.rid, re.id);
            end
        end
        if (!rst && bus.rvalid) begin
            if (stall_seen) check("r_stall_hold", bus.rdata, stall_data);
            stall_seen = !bus.rready;
            stall_data = bus.rdata;
        end else begin
            stall_seen = 1'b0;
        end
    end

    // rready: always high, or the repeating 1,0,0 pattern when toggling is requested.
    initial begin
        int ph;
        ph = 0;
        bus.rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rready_toggle) begin
                ph = (ph + 1) % 3;
                bus.rready = (ph == 0);
            end else begin
                ph = 0;
                bus.rready = 1'b1;
            end
        end
    end

    function automatic logic chan_ready(input int c);
        case (c)
            0:       return bus.awready;
            1:       return bus.wready;
            default: return bus.arready;
        endcase
    endfunction

    // Returns just after the edge on which the channel handshake happened.
    task automatic wait_ready(input int c, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!chan_ready(c) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!chan_ready(c)) check({name, "_ready_timeout"}, chan_ready(c), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b_empty();
        int n;
        n = 0;
        while (exp_b_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_b_q.size() != 0) begin
            check("b_timeout_pending", exp_b_q.size(), 0);
            exp_b_q.delete();
        end
    endtask

    task automatic wait_r_empty();
        int n;
        n = 0;
        while (exp_r_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_r_q.size() != 0) begin
            check("r_timeout_pending", exp_r_q.size(), 0);
            exp_r_q.delete();
        end
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                               input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                               input logic [3:0] strb, input int early, input logic [1:0] resp);
        b_exp_t be;
        be.id   = id;
        be.resp = resp;
        exp_b_q.push_back(be);
        exp_wr_cnt++;
        bus.awaddr  = addr;
        bus.awid    = id;
        bus.awlen   = len;
        bus.awsize  = size;
        bus.awburst = burst;
        bus.awvalid = 1'b1;
        wait_ready(0, "aw");
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus.wdata  = d0 + 32'(i);
            bus.wstrb  = strb;
            bus.wlast  = (early >= 0) ? (i == early) : (i == int'(len));
            bus.wvalid = 1'b1;
            wait_ready(1, "w");
        end
        bus.wvalid = 1'b0;
        check("b_latency_bvalid", bus.bvalid, 1);
        wait_b_empty();
        check("wr_done_cnt", wr_done_cnt, exp_wr_cnt);
    endtask

    task automatic push_r(input logic [3:0] id, input logic [7:0] len, input int beats,
                          input logic [31:0] d0, input logic [31:0] step, input logic [1:0] resp);
        r_exp_t re;
        for (int i = 0; i < beats; i++) begin
            re.data = d0 + step * 32'(i);
            re.resp = resp;
            re.last = (i == int'(len));
            re.id   = id;
            exp_r_q.push_back(re);
        end
    endtask

    task automatic issue_ar(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bus.araddr  = addr;
        bus.arid    = id;
        bus.arlen   = len;
        bus.arsize  = size;
        bus.arburst = burst;
        bus.arvalid = 1'b1;
        wait_ready(2, "ar");
        bus.arvalid = 1'b0;
        check("r_latency_rvalid", bus.rvalid, 1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic [31:0] d0,
                              input logic [31:0] step, input logic [1:0] resp);
        push_r(id, len, int'(len) + 1, d0, step, resp);
        exp_rd_cnt++;
        issue_ar(addr, id, len, size, burst);
        wait_r_empty();
        check("rd_done_cnt", rd_done_cnt, exp_rd_cnt);
        check("arready_after_read", bus.arready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
        bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.bready = 1'b1;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
        bus.arsize = '0; bus.arburst = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", bus.awready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_wr_done_cnt", wr_done_cnt, 0);
        check("rst_rd_done_cnt", rd_done_cnt, 0);
        check("rst_wr_state", wr_state, W_IDLE);
        check("rst_rd_state", rd_state, R_IDLE);
        rst = 1'b0;
        #1;
        check("awready_before_first_edge", bus.awready, 0);
        @(posedge clk);
        #1;
        check("awready_after_release", bus.awready, 1);
        check("arready_after_release", bus.arready, 1);

        // Single write then read.
        write_burst(32'h10, 4'd1, 8'd0, 3'd2, BURST_INCR, 32'hABCD1234, 4'hF, -1, RESP_OKAY);
        read_burst(32'h10, 4'd2, 8'd0, 3'd2, BURST_INCR, 32'hABCD1234, 32'd0, RESP_OKAY);

        // Four-beat INCR burst, read back under rready backpressure.
        write_burst(32'h40, 4'd3, 8'd3, 3'd2, BURST_INCR, 32'h1, 4'hF, -1, RESP_OKAY);
        rready_toggle = 1'b1;
        read_burst(32'h40, 4'd4, 8'd3, 3'd2, BURST_INCR, 32'h1, 32'd1, RESP_OKAY);
        rready_toggle = 1'b0;

        // Partial strobe overwrite of the low half.
        write_burst(32'h20, 4'd5, 8'd0, 3'd2, BURST_INCR, 32'hFFFFFFFF, 4'hF, -1, RESP_OKAY);
        write_burst(32'h20, 4'd6, 8'd0, 3'd2, BURST_INCR, 32'h00000000, 4'h3, -1, RESP_OKAY);
        read_burst(32'h20, 4'd7, 8'd0, 3'd2, BURST_INCR, 32'hFFFF0000, 32'd0, RESP_OKAY);

        // Out-of-range and top-crossing writes alias word 0 and must leave it untouched.
        write_burst(32'h0, 4'd8, 8'd0, 3'd2, BURST_INCR, 32'h5A5A5A5A, 4'hF, -1, RESP_OKAY);
        write_burst(32'h400, 4'd9, 8'd0, 3'd2, BURST_INCR, 32'hDEADBEEF, 4'hF, -1, RESP_DECERR);
        read_burst(32'h0, 4'd10, 8'd0, 3'd2, BURST_INCR, 32'h5A5A5A5A, 32'd0, RESP_OKAY);
        read_burst(32'h400, 4'd11, 8'd0, 3'd2, BURST_INCR, 32'h0, 32'd0, RESP_DECERR);
        write_burst(32'h3F8, 4'd12, 8'd3, 3'd2, BURST_INCR, 32'h11, 4'hF, -1, RESP_DECERR);
        read_burst(32'h0, 4'd10, 8'd0, 3'd2, BURST_INCR, 32'h5A5A5A5A, 32'd0, RESP_OKAY);

        // WRAP read is rejected with zeroed data.
        read_burst(32'h40, 4'd13, 8'd1, 3'd2, BURST_WRAP, 32'h0, 32'd0, RESP_SLVERR);

        // Early wlast and a narrow transfer size.
        write_burst(32'h60, 4'd14, 8'd1, 3'd2, BURST_INCR, 32'h55, 4'hF, 0, RESP_SLVERR);
        write_burst(32'h64, 4'd15, 8'd0, 3'd2, BURST_INCR, 32'h12345678, 4'hF, -1, RESP_OKAY);
        write_burst(32'h64, 4'd15, 8'd0, 3'd1, BURST_INCR, 32'h99, 4'hF, -1, RESP_SLVERR);
        read_burst(32'h64, 4'd1, 8'd0, 3'd2, BURST_INCR, 32'h12345678, 32'd0, RESP_OKAY);

        // FIXED bursts keep hitting one word.
        write_burst(32'h30, 4'd1, 8'd2, 3'd2, BURST_FIXED, 32'h7, 4'hF, -1, RESP_OKAY);
        read_burst(32'h30, 4'd2, 8'd1, 3'd2, BURST_FIXED, 32'h9, 32'd0, RESP_OKAY);

        // Reset while beat 2 of a 4-beat read is on the bus.
        push_r(4'd5, 8'd3, 2, 32'h1, 32'd1, RESP_OKAY);
        issue_ar(32'h40, 4'd5, 8'd3, 3'd2, BURST_INCR);
        wait_r_empty();
        check("pre_rst_rvalid_beat2", bus.rvalid, 1);
        rst = 1'b1;
        #1;
        exp_r_q.delete();
        exp_wr_cnt = 0;
        exp_rd_cnt = 0;
        check("midrst_rvalid", bus.rvalid, 0);
        check("midrst_arready", bus.arready, 0);
        check("midrst_rd_state", rd_state, R_IDLE);
        check("midrst_rd_done_cnt", rd_done_cnt, exp_rd_cnt);
        check("midrst_wr_done_cnt", wr_done_cnt, exp_wr_cnt);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arready_before_edge_2", bus.arready, 0);
        @(posedge clk);
        #1;
        check("arready_after_release_2", bus.arready, 1);
        write_burst(32'h80, 4'd6, 8'd0, 3'd2, BURST_INCR, 32'h77, 4'hF, -1, RESP_OKAY);
        read_burst(32'h80, 4'd7, 8'd0, 3'd2, BURST_INCR, 32'h77, 32'd0, RESP_OKAY);

        repeat (3) @(posedge clk);
        #1;
        check("b_queue_drained", exp_b_q.size(), 0);
        check("r_queue_drained", exp_r_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

AXI4 memory-mapped slave responder that sits directly downstream of the bridge's slave-side user AXI port (`s_user_axi_if`) and terminates the traffic the bridge delivers. It accepts AW/W bursts into an internal word-addressed RAM and returns B responses. It serves AR bursts with R beats, giving the far-end master real read-back data for end-to-end bring-up. The write and read paths are independent state machines that share one RAM.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width
- `DATA_W`, 32, data width (8/16/32/64); `BYTES = DATA_W/8`
- `ID_W`, 4, AXI ID width
- `DEPTH_LOG2`, 8, RAM depth in words (`2**DEPTH_LOG2`)

Ports (all synchronous to `clk`):
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: reset, asynchronous and active-high
- `s_axi_if` interface: AXI4 slave modport
  - AW: `awvalid`/`awready`/`awaddr`/`awid`/`awlen[7:0]`/`awsize[2:0]`/`awburst[1:0]`
  - W: `wvalid`/`wready`/`wdata`/`wstrb`/`wlast`
  - B: `bvalid`/`bready`/`bresp`/`bid`
  - AR: `arvalid`/`arready`/`araddr`/`arid`/`arlen`/`arsize`/`arburst`
  - R: `rvalid`/`rready`/`rdata`/`rresp`/`rid`/`rlast`
- `wr_done_cnt` out 16: completed write bursts (B handshakes), wraps at 0xFFFF→0
- `rd_done_cnt` out 16: completed read bursts (last R handshake), wraps

## Operation
- Write FSM:
  - `W_IDLE`: awready=1. On AW handshake, latch addr/id/len/burst and compute the error code, then go to `W_DATA`.
  - `W_DATA`: wready=1. Each W handshake writes `wdata` under `wstrb` byte enables, unless error is set. Beat counter increments. On beat `awlen`, go to `W_RESP`.
  - `W_RESP`: bvalid=1 with latched bid/bresp. On bready, go to `W_IDLE`.
- Read FSM:
  - `R_IDLE`: arready=1. On AR handshake, latch the request and go to `R_DATA`.
  - `R_DATA`: rvalid asserted per beat. On beat `arlen` handshake, go to `R_IDLE`.
- Address and response rules:
  - Word index = `addr[DEPTH_LOG2+log2(BYTES)-1 : log2(BYTES)]`.
  - INCR: address += BYTES per beat. FIXED: address constant.
  - DECERR (2'b11): address beyond `BYTES*2**DEPTH_LOG2`, or an INCR burst that crosses the top. Applies to the whole burst.
  - SLVERR (2'b10): any of:
    - `awsize/arsize != log2(BYTES)`
    - burst == WRAP or reserved
    - `wlast` value mismatches the beat count; late SLVERR applies to B only; beats already written stay written
  - Erroring bursts: writes suppressed; rdata=0.
  - OKAY (2'b00) otherwise.
- RAM is not reset. Contents after reset are undefined.

## Timing
- During `rst`: all outputs 0, both FSMs in IDLE, counters 0. awready/arready rise on the first `clk` edge after `rst` falls.
- `rst` mid-burst aborts immediately; no B or R is issued for the aborted burst.
- Write latency: bvalid rises one cycle after the last W handshake.
- Read latency: first rvalid one cycle after the AR handshake (synchronous RAM read). Beats are back-to-back while rready=1.
- R stall: when rready=0, rdata/rresp/rlast/rvalid hold stable. The RAM read for the next beat is prefetched only on handshake.
- AW/AR acceptance is single-outstanding per direction: awready=0 outside `W_IDLE`, arready=0 outside `R_IDLE`.
- Simultaneous RAM write and read to the same word in one cycle: the read returns the old data (read-first).
- Counters increment in the handshake cycle and update the following cycle.

## Structure
- Package `axi_mem_pkg` holds:
  - resp codes (OKAY/SLVERR/DECERR)
  - burst codes (FIXED/INCR/WRAP)
  - `wr_state_t` {`W_IDLE`, `W_DATA`, `W_RESP`}
  - `rd_state_t` {`R_IDLE`, `R_DATA`}
- Sub-module `axi_mem_ram`: simple dual-port RAM, one byte-enabled write port, one synchronous read port with read enable, read-first behaviour.

## Test plan
- Single write then read:
  - Stimulus: AW addr 0x10, len 0, size 2, INCR; W 0xABCD1234, strb 0xF.
  - Response: bresp 00; AR to same address returns rdata 0xABCD1234, rlast=1, rresp 00.
  - Counters: wr_done_cnt=1, rd_done_cnt=1.
- INCR burst with backpressure:
  - Stimulus: write 4 beats 0x1..0x4 at 0x40; read len 3 with rready toggling 1,0,0,1,…
  - Response: beats 0x1..0x4 in order, data stable during stalls, rlast only on beat 3.
- Partial strobe:
  - Stimulus: write 0xFFFFFFFF, then 0x00000000 with strb 0x3.
  - Response: read returns 0xFFFF0000.
- Error paths:
  - Address 0x400 (DEPTH_LOG2=8, 32-bit data): bresp 11, RAM unchanged.
  - WRAP read: 2 beats with rresp 10, rdata 0.
  - wlast asserted early: bresp 10.
- Reset mid-read:
  - Stimulus: assert rst during beat 2 of 4.
  - Response: rvalid=0 immediately, arready=1 the cycle after release; a new read completes normally.
